// File: rtl/sim_helper_pkg.sv
// Shared constants and the xorshift32 step for the sim clock/random block.
package sim_helper_pkg;

   localparam int          CLK_DIV      = 8;
   localparam int          LOCK_CYCLES  = 64;
   localparam int          TIME_W       = 64;
   localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

   function automatic logic [31:0] xorshift32(input logic [31:0] x);
      logic [31:0] t;
      t = x ^ (x << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
      return t;
   endfunction

endpackage

// File: rtl/sim_rand_range.sv
// Seeded xorshift32 generator with a 2-stage range-scaling pipeline.
module sim_rand_range
   import sim_helper_pkg::*;
#(
   parameter logic [31:0] SEED_DEF = DEFAULT_SEED
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        init_i,
   input  logic [31:0] seed_i,
   input  logic        req_i,
   input  logic [31:0] max_i,
   input  logic [31:0] min_i,
   output logic        valid_o,
   output logic [31:0] out_o
);

   logic [31:0] x_q, x_d;
   logic        v1_q, v1_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] xn_q, xn_d;
   logic [32:0] span_q, span_d;
   logic        valid_q, valid_d;
   logic [31:0] out_q, out_d;

   logic [31:0] x_next;
   logic [31:0] diff;
   logic [64:0] prod;
   logic        unused_prod;

   // Stage 1: advance state on an accepted request and latch the bounds.
   always_comb begin
      x_next = xorshift32(x_q);
      diff   = '0;
      x_d    = x_q;
      v1_d   = 1'b0;
      lo_d   = lo_q;
      xn_d   = xn_q;
      span_d = span_q;
      if (init_i) begin
         x_d = (seed_i == '0) ? SEED_DEF : seed_i;
      end else if (req_i) begin
         x_d  = x_next;
         xn_d = x_next;
         v1_d = 1'b1;
         if (max_i < min_i) begin
            lo_d = max_i;
            diff = min_i - max_i;
         end else begin
            lo_d = min_i;
            diff = max_i - min_i;
         end
         span_d = {1'b0, diff} + 33'd1;
      end
   end

   // Stage 2: lo + floor(x * span / 2^32); the quotient is always < 2^32.
   always_comb begin
      prod    = {33'd0, xn_q} * {32'd0, span_q};
      valid_d = v1_q;
      out_d   = out_q;
      if (v1_q) begin
         out_d = lo_q + prod[63:32];
      end
   end

   assign unused_prod = ^{prod[64], prod[31:0]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q     <= SEED_DEF;
         v1_q    <= 1'b0;
         lo_q    <= '0;
         xn_q    <= '0;
         span_q  <= '0;
         valid_q <= 1'b0;
         out_q   <= '0;
      end else begin
         x_q     <= x_d;
         v1_q    <= v1_d;
         lo_q    <= lo_d;
         xn_q    <= xn_d;
         span_q  <= span_d;
         valid_q <= valid_d;
         out_q   <= out_d;
      end
   end

   assign valid_o = valid_q;
   assign out_o   = out_q;

endmodule

// File: rtl/sim_clk_rand_gen.sv
// Bench support: CLK_L divider, LOCKED flag, SYS_TIME counter and a
// seeded range-limited random source.
module sim_clk_rand_gen
   import sim_helper_pkg::*;
#(
   parameter int          P_CLK_DIV     = sim_helper_pkg::CLK_DIV,
   parameter int          P_LOCK_CYCLES = sim_helper_pkg::LOCK_CYCLES,
   parameter int          P_TIME_W      = sim_helper_pkg::TIME_W,
   parameter logic [31:0] P_SEED        = sim_helper_pkg::DEFAULT_SEED
) (
   input  logic                CLK,
   input  logic                RST_N,
   output logic                CLK_L,
   output logic                LOCKED,
   output logic [P_TIME_W-1:0] SYS_TIME,
   input  logic                RND_INIT,
   input  logic [31:0]         SEED_IN,
   input  logic                RND_REQ,
   input  logic [31:0]         RND_MAX,
   input  logic [31:0]         RND_MIN,
   output logic                RND_VALID,
   output logic [31:0]         RND_OUT
);

   localparam int DIV_W  = $clog2(P_CLK_DIV);
   localparam int LOCK_W = $clog2(P_LOCK_CYCLES + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(P_CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(P_CLK_DIV / 2);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(P_LOCK_CYCLES - 1);

   logic [DIV_W-1:0]    div_q, div_d;
   logic                clkl_q, clkl_d;
   logic [LOCK_W-1:0]   lcnt_q, lcnt_d;
   logic                locked_q, locked_d;
   logic [P_TIME_W-1:0] time_q, time_d;

   // Divider resets to its last count so the first edge after release
   // lands on count 0, which is the CLK_L rising edge.
   always_comb begin
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      clkl_d = (div_d < DIV_HALF);
   end

   always_comb begin
      lcnt_d   = lcnt_q;
      locked_d = locked_q;
      if (!locked_q) begin
         if (lcnt_q == LOCK_LAST) begin
            locked_d = 1'b1;
         end else begin
            lcnt_d = lcnt_q + 1'b1;
         end
      end
      time_d = locked_q ? time_q + P_TIME_W'(1) : '0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         div_q    <= DIV_LAST;
         clkl_q   <= 1'b0;
         lcnt_q   <= '0;
         locked_q <= 1'b0;
         time_q   <= '0;
      end else begin
         div_q    <= div_d;
         clkl_q   <= clkl_d;
         lcnt_q   <= lcnt_d;
         locked_q <= locked_d;
         time_q   <= time_d;
      end
   end

   assign CLK_L    = clkl_q;
   assign LOCKED   = locked_q;
   assign SYS_TIME = time_q;

   sim_rand_range #(
      .SEED_DEF (P_SEED)
   ) u_rand (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .init_i  (RND_INIT),
      .seed_i  (SEED_IN),
      .req_i   (RND_REQ),
      .max_i   (RND_MAX),
      .min_i   (RND_MIN),
      .valid_o (RND_VALID),
      .out_o   (RND_OUT)
   );

endmodule

// File: tb/tb_sim_clk_rand_gen.sv
// Directed self-checking bench for sim_clk_rand_gen.
module tb_sim_clk_rand_gen;

   logic        CLK;
   logic        RST_N;
   logic        CLK_L;
   logic        LOCKED;
   logic [63:0] SYS_TIME;
   logic        RND_INIT;
   logic [31:0] SEED_IN;
   logic        RND_REQ;
   logic [31:0] RND_MAX;
   logic [31:0] RND_MIN;
   logic        RND_VALID;
   logic [31:0] RND_OUT;

   int n_total = 0;
   int n_pass  = 0;

   sim_clk_rand_gen dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .CLK_L     (CLK_L),
      .LOCKED    (LOCKED),
      .SYS_TIME  (SYS_TIME),
      .RND_INIT  (RND_INIT),
      .SEED_IN   (SEED_IN),
      .RND_REQ   (RND_REQ),
      .RND_MAX   (RND_MAX),
      .RND_MIN   (RND_MIN),
      .RND_VALID (RND_VALID),
      .RND_OUT   (RND_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] seed;
      logic [31:0] mx;
      logic [31:0] mn;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Seed, one request, check the 2-cycle latency, value and hold.
   task automatic run_vec(input int idx, input vec_t v);
      RND_INIT = 1'b1;
      SEED_IN  = v.seed;
      tick();
      RND_INIT = 1'b0;
      RND_REQ  = 1'b1;
      RND_MAX  = v.mx;
      RND_MIN  = v.mn;
      tick();
      RND_REQ = 1'b0;
      chk($sformatf("vec%0d_lat1", idx), {63'd0, RND_VALID}, 64'd0);
      tick();
      chk($sformatf("vec%0d_valid", idx), {63'd0, RND_VALID}, 64'd1);
      chk($sformatf("vec%0d_out", idx), {32'd0, RND_OUT}, {32'd0, v.exp});
      tick();
      chk($sformatf("vec%0d_hold", idx),
          {31'd0, RND_VALID, RND_OUT}, {32'd0, v.exp});
   endtask

   // Request a stream of 100 back-to-back values after seeding with 1.
   task automatic stream(output logic [31:0] seq[100], output int nv,
                         output int nbad);
      nv   = 0;
      nbad = 0;
      RND_INIT = 1'b1;
      SEED_IN  = 32'd1;
      tick();
      RND_INIT = 1'b0;
      RND_MAX  = 32'd248;
      RND_MIN  = 32'd0;
      for (int c = 0; c < 104; c++) begin
         RND_REQ = (c < 100);
         tick();
         if (RND_VALID) begin
            if (nv < 100) seq[nv] = RND_OUT;
            if (RND_OUT > 32'd248) nbad++;
            nv++;
         end
      end
      RND_REQ = 1'b0;
   endtask

   initial begin
      logic [31:0] s1[100];
      logic [31:0] s2[100];
      int   nv1, nv2, nb1, nb2, ndiff;
      int   lock_edge, rises, first_rise, clk_bad, nvalid;
      logic prev_l;
      logic [63:0] t64, t65, t66;

      vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0004_2021};
      vecs[1] = '{32'h0000_0001, 32'd4096, 32'd4096, 32'd4096};
      vecs[2] = '{32'h0004_2021, 32'd248, 32'd0, 32'd3};
      vecs[3] = '{32'h0004_2021, 32'd2000, 32'd8000, 32'd2094};
      vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0004_2021};
      vecs[5] = '{32'h0004_2021, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0408_0601};
      vecs[6] = '{32'h0004_2021, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8204_0300};
      vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8008_4000};
      vecs[8] = '{32'h8000_0000, 32'd10, 32'd5, 32'd8};

      RST_N    = 1'b0;
      RND_INIT = 1'b0;
      SEED_IN  = '0;
      RND_REQ  = 1'b0;
      RND_MAX  = '0;
      RND_MIN  = '0;
      repeat (3) tick();
      chk("rst_clkl", {63'd0, CLK_L}, 64'd0);
      chk("rst_locked", {63'd0, LOCKED}, 64'd0);
      chk("rst_time", SYS_TIME, 64'd0);
      chk("rst_rnd", {31'd0, RND_VALID, RND_OUT}, 64'd0);

      // Lock timing, SYS_TIME start and CLK_L waveform from release.
      RST_N      = 1'b1;
      lock_edge  = -1;
      rises      = 0;
      first_rise = -1;
      clk_bad    = 0;
      prev_l     = 1'b0;
      t64 = '1; t65 = '1; t66 = '1;
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (LOCKED && lock_edge < 0) lock_edge = k;
         if (k == 64) t64 = SYS_TIME;
         if (k == 65) t65 = SYS_TIME;
         if (k == 66) t66 = SYS_TIME;
         if (CLK_L !== (((k - 1) % 8) < 4)) clk_bad++;
         if (CLK_L && !prev_l) begin
            rises++;
            if (first_rise < 0) first_rise = k;
         end
         prev_l = CLK_L;
      end
      chk("lock_edge", 64'(lock_edge), 64'd64);
      chk("time_0", t64, 64'd0);
      chk("time_1", t65, 64'd1);
      chk("time_2", t66, 64'd2);
      chk("clkl_first_rise", 64'(first_rise), 64'd1);
      chk("clkl_rises", 64'(rises), 64'd10);
      chk("clkl_shape_errs", 64'(clk_bad), 64'd0);

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // INIT wins over a simultaneous REQ; the request is dropped.
      RND_INIT = 1'b1;
      SEED_IN  = 32'h8000_0000;
      RND_REQ  = 1'b1;
      RND_MAX  = 32'hFFFF_FFFF;
      RND_MIN  = 32'd0;
      tick();
      RND_INIT = 1'b0;
      RND_REQ  = 1'b0;
      nvalid   = 0;
      repeat (3) begin
         tick();
         if (RND_VALID) nvalid++;
      end
      chk("init_drop_valid", 64'(nvalid), 64'd0);
      RND_REQ = 1'b1;
      tick();
      RND_REQ = 1'b0;
      tick();
      chk("init_prio_out", {31'd0, RND_VALID, RND_OUT},
          {31'd0, 1'b1, 32'h8008_4000});

      stream(s1, nv1, nb1);
      stream(s2, nv2, nb2);
      ndiff = 0;
      for (int i = 0; i < 100; i++) if (s1[i] !== s2[i]) ndiff++;
      chk("stream_count", 64'(nv1), 64'd100);
      chk("stream_range", 64'(nb1), 64'd0);
      chk("stream_v0", {32'd0, s1[0]}, 64'd0);
      chk("stream_v1", {32'd0, s1[1]}, 64'd3);
      chk("restream_count", 64'(nv2), 64'd100);
      chk("restream_same", 64'(ndiff), 64'd0);

      // Reset with a request in flight.
      RND_REQ = 1'b1;
      RND_MAX = 32'hFFFF_FFFF;
      RND_MIN = 32'd0;
      @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      chk("midrst_outs", {CLK_L, LOCKED, RND_VALID, RND_OUT, 29'd0}, 64'd0);
      chk("midrst_time", SYS_TIME, 64'd0);
      @(negedge CLK);
      RND_REQ = 1'b0;
      tick();
      RST_N     = 1'b1;
      lock_edge = -1;
      nvalid    = 0;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (RND_VALID) nvalid++;
         if (LOCKED && lock_edge < 0) lock_edge = k;
      end
      chk("midrst_no_valid", 64'(nvalid), 64'd0);
      chk("relock_edge", 64'(lock_edge), 64'd64);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
